// File: rtl/banco_registro_param.sv
// banco_registro_param: parametrised register bank with N_RD combinational read ports, one write port and a clear-sweep sequencer.
//   Ports: CLK/RST (sync, active-high), RA (N_RD packed read addresses), DR (N_RD packed read data),
//   Di/Dir/RegWrite (write port), Clr (sweep request), Busy (sweep active), WrDrop (write discarded pulse).
//   Optional macro REGFILE_BYPASS_EN: same-cycle write-to-read forwarding.
module banco_registro_param #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int N_RD     = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [N_RD*ADDR_W-1:0]   RA,
  output logic [N_RD*DATA_W-1:0]   DR,
  input  logic [DATA_W-1:0]        Di,
  input  logic [ADDR_W-1:0]        Dir,
  input  logic                     RegWrite,
  input  logic                     Clr,
  output logic                     Busy,
  output logic                     WrDrop
);
  localparam int DEPTH = 2**ADDR_W;
  typedef enum logic {S_IDLE, S_CLEAR} state_t;
  state_t              r_state;
  logic [ADDR_W-1:0]   r_cnt;
  logic                r_busy;
  logic                r_wrdrop;
  logic [DATA_W-1:0]   r_mem [DEPTH];
  logic                w_zero_wr;
  logic                w_wr_ok;
  logic                w_we;
  logic [ADDR_W-1:0]   w_waddr;
  logic [DATA_W-1:0]   w_wdata;
  assign w_zero_wr = (ZERO_REG != 0) && (Dir == '0);
  assign w_wr_ok   = (r_state == S_IDLE) && !Clr && RegWrite && !w_zero_wr;
  // the sweep and normal writes share the single storage write port
  assign w_we    = !RST && ((r_state == S_CLEAR) || w_wr_ok);
  assign w_waddr = (r_state == S_CLEAR) ? r_cnt : Dir;
  assign w_wdata = (r_state == S_CLEAR) ? '0 : Di;
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state  <= S_CLEAR;
      r_cnt    <= '0;
      r_busy   <= 1'b1;
      r_wrdrop <= 1'b0;
    end else if (r_state == S_CLEAR) begin
      r_cnt    <= r_cnt + ADDR_W'(1);
      r_wrdrop <= RegWrite;
      if (&r_cnt) begin
        r_state <= S_IDLE;
        r_busy  <= 1'b0;
      end
    end else begin
      r_wrdrop <= Clr && RegWrite;
      if (Clr) begin
        r_state <= S_CLEAR;
        r_cnt   <= '0;
        r_busy  <= 1'b1;
      end
    end
  end
  always_ff @(posedge CLK) begin
    if (w_we) r_mem[w_waddr] <= w_wdata;
  end
  for (genvar i = 0; i < N_RD; i++) begin : g_rd
    logic [ADDR_W-1:0] w_ra;
    logic              w_mask;
    logic [DATA_W-1:0] w_rd;
    assign w_ra   = RA[i*ADDR_W +: ADDR_W];
    assign w_mask = r_busy || ((ZERO_REG != 0) && (w_ra == '0));
`ifdef REGFILE_BYPASS_EN
    assign w_rd = (w_wr_ok && (w_ra == Dir)) ? Di : r_mem[w_ra];
`else
    assign w_rd = r_mem[w_ra];
`endif
    assign DR[i*DATA_W +: DATA_W] = w_mask ? '0 : w_rd;
  end
  assign Busy   = r_busy;
  assign WrDrop = r_wrdrop;
endmodule

// File: tb/tb_banco_registro_param.sv
// tb_banco_registro_param: directed self-checking bench for banco_registro_param with three read ports.
module tb_banco_registro_param;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [14:0] ra = '0;
  logic [95:0] dr;
  logic [31:0] di = '0;
  logic [4:0]  dir = '0;
  logic        we = 1'b0;
  logic        clr = 1'b0;
  logic        busy;
  logic        wrdrop;
  int          errors = 0;
  int          checks = 0;
  int          n;
  logic [31:0] hz_exp;
  banco_registro_param #(.DATA_W(32), .ADDR_W(5), .N_RD(3), .ZERO_REG(1)) dut (
    .CLK(clk), .RST(rst), .RA(ra), .DR(dr), .Di(di), .Dir(dir),
    .RegWrite(we), .Clr(clr), .Busy(busy), .WrDrop(wrdrop)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic count_sweep(input int start);
    n = start;
    while (busy === 1'b1 && n < 100) begin
      tick();
      n++;
    end
  endtask
  initial begin
    #1;
    tick();
    tick();
    check("rst_busy", 96'(busy), 96'd1);
    check("rst_wrdrop", 96'(wrdrop), 96'd0);
    check("rst_dr", dr, 96'd0);
    rst = 1'b0;
    count_sweep(0);
    check("sweep_len", 96'(n), 96'd32);
    for (int a = 0; a < 32; a++) begin
      ra = {5'(a), 5'(a), 5'(a)};
      #1;
      check("cleared", dr, 96'd0);
    end
    we = 1'b1; dir = 5'd5; di = 32'hDEADBEEF;
    tick();
    we = 1'b0; ra = {5'd0, 5'd5, 5'd5};
    #1;
    check("rd5_p0", 96'(dr[31:0]), 96'h0DEADBEEF);
    check("rd5_p1", 96'(dr[63:32]), 96'h0DEADBEEF);
    check("wrdrop_ok", 96'(wrdrop), 96'd0);
    we = 1'b1; dir = 5'd0; di = 32'h12345678;
    tick();
    we = 1'b0; ra = '0;
    #1;
    check("zero_reg", dr, 96'd0);
    check("zero_wrdrop", 96'(wrdrop), 96'd0);
    we = 1'b1; dir = 5'd7; di = 32'h11;
    tick();
    di = 32'h22; ra = {5'd0, 5'd0, 5'd7};
    #1;
`ifdef REGFILE_BYPASS_EN
    hz_exp = 32'h22;
`else
    hz_exp = 32'h11;
`endif
    check("hazard_same", 96'(dr[31:0]), 96'(hz_exp));
    tick();
    we = 1'b0;
    #1;
    check("hazard_next", 96'(dr[31:0]), 96'h22);
    we = 1'b1; dir = 5'd1; di = 32'h101;
    tick();
    dir = 5'd2; di = 32'h202;
    tick();
    dir = 5'd3; di = 32'hAAAA;
    tick();
    we = 1'b0; ra = {5'd3, 5'd2, 5'd1};
    #1;
    check("p0_addr1", 96'(dr[31:0]), 96'h101);
    check("p1_addr2", 96'(dr[63:32]), 96'h202);
    check("p2_addr3", 96'(dr[95:64]), 96'hAAAA);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("clr_busy", 96'(busy), 96'd1);
    check("clr_mask", dr, 96'd0);
    we = 1'b1; dir = 5'd9; di = 32'h55;
    tick();
    we = 1'b0;
    check("drop_pulse", 96'(wrdrop), 96'd1);
    check("drop_busy", 96'(busy), 96'd1);
    tick();
    check("drop_end", 96'(wrdrop), 96'd0);
    count_sweep(2);
    check("clr_len", 96'(n), 96'd32);
    ra = {5'd1, 5'd9, 5'd3};
    #1;
    check("clr_rd", dr, 96'd0);
    clr = 1'b1; we = 1'b1; dir = 5'd4; di = 32'h44;
    tick();
    clr = 1'b0; we = 1'b0;
    check("clr_edge_drop", 96'(wrdrop), 96'd1);
    for (int k = 0; k < 9; k++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_busy", 96'(busy), 96'd1);
    check("midrst_wrdrop", 96'(wrdrop), 96'd0);
    count_sweep(0);
    check("midrst_len", 96'(n), 96'd32);
    we = 1'b1; dir = 5'd31; di = 32'hCAFE0031;
    tick();
    we = 1'b0; ra = {5'd31, 5'd4, 5'd31};
    #1;
    check("top_addr", dr, {32'hCAFE0031, 32'd0, 32'hCAFE0031});
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
